serial_add_ctrl: RTL and testbench

//  Sequencer that performs a wide (SIZE*WORDS-bit) unsigned addition using one

---
 rtl/serial_add_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: wide unsigned adder sequencer. Drives one external SIZE-bit
// combinational slice adder, LS slice first, one slice per clock, and
// assembles the full sum and carry-out. Signals completion with a done pulse.
module serial_add_ctrl #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SIZE*WORDS-1:0] op_a,
  input  logic [SIZE*WORDS-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE*WORDS-1:0] sum,
  output logic                  cout,
  output logic [SIZE-1:0]       slc_a,
  output logic [SIZE-1:0]       slc_b,
  output logic                  slc_cin,
  input  logic [SIZE-1:0]       slc_s,
  input  logic                  slc_cf
);

  localparam int unsigned W    = SIZE * WORDS;
  // idx keeps at least one bit so WORDS=1 still has a legal (constant-0) index
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic            accept;

  assign accept = (state_q == StIdle) && start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: RUN lasts exactly WORDS cycles, DONE exactly one
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (idx_q == IdxLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: slice operands are forced to 0 outside RUN
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    slc_a   = '0;
    slc_b   = '0;
    slc_cin = 1'b0;
    unique case (state_q)
      StIdle: ;
      StRun: begin
        busy    = 1'b1;
        slc_a   = opa_q[idx_q*SIZE +: SIZE];
        slc_b   = opb_q[idx_q*SIZE +: SIZE];
        slc_cin = carry_q;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state: latch on accept, collect one slice per RUN cycle
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept) begin
      opa_d   = op_a;
      opb_d   = op_b;
      idx_d   = '0;
      carry_d = 1'b0;
      sum_d   = '0;
      cout_d  = 1'b0;
    end else if (state_q == StRun) begin
      sum_d[idx_q*SIZE +: SIZE] = slc_s;
      carry_d                   = slc_cf;
      if (idx_q == IdxLast) begin
        cout_d = slc_cf;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: self-checking bench for serial_add_ctrl. Models the
// external slice adder and compares results against plain wide addition.
module tb_serial_add_ctrl;

  localparam int unsigned SIZE  = 4;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = SIZE * WORDS;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic            busy;
  logic            done;
  logic [W-1:0]    sum;
  logic            cout;
  logic [SIZE-1:0] slc_a;
  logic [SIZE-1:0] slc_b;
  logic            slc_cin;
  logic [SIZE-1:0] slc_s;
  logic            slc_cf;

  int              n_checks;
  int              n_errors;
  logic [WORDS-1:0] last_cin;

  serial_add_ctrl #(
    .SIZE (SIZE),
    .WORDS(WORDS)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .slc_a  (slc_a),
    .slc_b  (slc_b),
    .slc_cin(slc_cin),
    .slc_s  (slc_s),
    .slc_cf (slc_cf)
  );

  // External slice adder
  always_comb begin
    {slc_cf, slc_s} = {1'b0, slc_a} + {1'b0, slc_b} + {{SIZE{1'b0}}, slc_cin};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full add from IDLE; checks slices, latency, result and hold after done
  task automatic run_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] exp;
    int         lat;
    int         rc;
    exp = {1'b0, a} + {1'b0, b};
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a  = W'($urandom);
    op_b  = W'($urandom);
    lat   = 0;
    rc    = 0;
    last_cin = '0;
    for (int n = 1; n <= int'(WORDS) + 3; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (busy && rc < int'(WORDS)) begin
        check({tag, " slice"}, 64'({slc_a, slc_b}),
              64'({a[rc*SIZE +: SIZE], b[rc*SIZE +: SIZE]}));
        last_cin[rc] = slc_cin;
        rc++;
      end
      @(negedge clk);
    end
    check({tag, " latency"}, 64'(lat), 64'(WORDS + 1));
    check({tag, " result"}, 64'({cout, sum}), 64'(exp));
    @(negedge clk);
    check({tag, " after done"}, 64'({done, busy}), 64'(0));
    check({tag, " held"}, 64'({cout, sum}), 64'(exp));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W:0]   hexp;
    int           ndone;
    int           done_at [$];
    int           guard;

    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op_a     = '0;
    op_b     = '0;

    // Reset state
    #12;
    check("rst busy/done", 64'({busy, done}), 64'(0));
    check("rst sum/cout", 64'({cout, sum}), 64'(0));
    check("rst slice", 64'({slc_a, slc_b, slc_cin}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_add("t1", 16'h1234, 16'h4321);
    check("t1 sum", 64'(sum), 64'h5555);
    run_add("t2", 16'hFFFF, 16'h0001);
    check("t2 cin", 64'(last_cin), 64'b1110);
    check("t2 res", 64'({cout, sum}), 64'h1_0000);
    run_add("t3a", 16'h8000, 16'h8000);
    run_add("t3b", 16'h0000, 16'h0000);

    // Start pulses during RUN and DONE are ignored
    @(negedge clk);
    op_a  = 16'h1111;
    op_b  = 16'h1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op_a  = 16'h0001;
    op_b  = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("t4 done seen", 64'(done), 64'(1));
    check("t4 result", 64'({cout, sum}), 64'h0_2222);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4 idle", 64'(busy), 64'(0));
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t4 no extra done", 64'(ndone), 64'(0));
    check("t4 held", 64'({cout, sum}), 64'h0_2222);

    // Reset during RUN cycle 2
    @(negedge clk);
    op_a  = 16'hABCD;
    op_b  = 16'h1357;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5 busy/done", 64'({busy, done}), 64'(0));
    check("t5 sum/cout", 64'({cout, sum}), 64'(0));
    check("t5 slice", 64'({slc_a, slc_b, slc_cin}), 64'(0));
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t5 no done", 64'(ndone), 64'(0));
    rst_n = 1'b1;
    run_add("t5 after", 16'hABCD, 16'h1357);

    // Start held high: one add every WORDS+2 cycles
    @(negedge clk);
    op_a  = 16'h9ABC;
    op_b  = 16'h7654;
    hexp  = {1'b0, op_a} + {1'b0, op_b};
    start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        done_at.push_back(n);
        check("t6 sum", 64'({cout, sum}), 64'(hexp));
      end else if (done_at.size() > 0 && done_at[done_at.size()-1] == n - 1) begin
        check("t6 hold", 64'({cout, sum}), 64'(hexp));
      end
    end
    start = 1'b0;
    check("t6 done count", 64'(done_at.size()), 64'(3));
    if (done_at.size() == 3) begin
      check("t6 first", 64'(done_at[0]), 64'(WORDS + 1));
      check("t6 period1", 64'(done_at[1] - done_at[0]), 64'(WORDS + 2));
      check("t6 period2", 64'(done_at[2] - done_at[1]), 64'(WORDS + 2));
    end
    guard = 0;
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("t6 drain", 64'(busy), 64'(0));

    // Random operands vs wide-add reference
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 10 == 0) ra = '1;
      run_add("rand", ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
